// File: rtl/mat_fifo_pkg.sv
// Shared types and constants for the FIFO-to-stream frame reader.
package mat_fifo_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

    localparam int unsigned CntW = 12;
    // Issued-read counter must hold IMG_WIDTH*IMG_HEIGHT.
    localparam int unsigned TotW = 2 * CntW;

endpackage

// File: rtl/mat_fifo_rd_stream_if.sv
// FIFO read port plus framed output stream, grouped for the frame reader.
interface mat_fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof
    );
endinterface

// File: rtl/mat_fifo_rd_buf.sv
// Small circular skid buffer absorbing FIFO read latency; head is always presented.
module mat_fifo_rd_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mat_fifo_rd_stream.sv
// Reads one frame of IMG_WIDTH*IMG_HEIGHT words from a FIFO and emits it as a
// valid/ready stream with start-of-frame, end-of-line and end-of-frame markers.
module mat_fifo_rd_stream
    import mat_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 frame_start,
    mat_fifo_rd_stream_if.master bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int unsigned Lat   = 1 + OUT_REG;
    localparam int unsigned Depth = Lat + 1;
    localparam int unsigned BufCw = $clog2(Depth + 1);
    localparam logic [TotW-1:0] Total   = TotW'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [CntW-1:0] LastCol = CntW'(IMG_WIDTH - 1);
    localparam logic [CntW-1:0] LastRow = CntW'(IMG_HEIGHT - 1);

    rd_state_e             state_q, state_d;
    logic [TotW-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0]       col_q, col_d, row_q, row_d;
    logic [Lat-1:0]        pipe_q, pipe_d;
    logic [BufCw-1:0]      count;
    logic [1:0]            inflight;
    logic [2:0]            occ;
    logic                  rd_en, push, pop, done;
    logic [DATA_WIDTH-1:0] head;

    // pipe_q tracks outstanding reads; the oldest lands in the buffer this cycle.
    assign push = pipe_q[Lat-1];
    assign pop  = bus.m_valid && bus.m_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < Lat; i++) inflight = inflight + 2'(pipe_q[i]);
    end

    // A pop in the same cycle frees a slot, which keeps full rate sustainable.
    assign occ   = 3'(inflight) + 3'(count) - 3'(pop);
    assign rd_en = (state_q == StRun) && !bus.fifo_empty && (rd_cnt_q < Total)
                   && (occ < 3'(Depth));
    assign done  = (state_q == StDrain) && (count == '0) && (pipe_q == '0);

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        col_d    = col_q;
        row_d    = row_q;
        pipe_d   = Lat'({pipe_q, rd_en});
        if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
        if (pop) begin
            if (col_q == LastCol) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        unique case (state_q)
            StIdle:  if (frame_start) state_d = StRun;
            StRun:   if (rd_en && (rd_cnt_q == Total - 1'b1)) state_d = StDrain;
            StDrain: begin
                if (done) begin
                    state_d  = StIdle;
                    rd_cnt_d = '0;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q  <= StIdle;
            rd_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pipe_q   <= pipe_d;
        end
    end

    mat_fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (Depth)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (count != '0);
    assign bus.m_data     = head;
    assign bus.m_sof      = bus.m_valid && (col_q == '0) && (row_q == '0);
    assign bus.m_eol      = bus.m_valid && (col_q == LastCol);
    assign bus.m_eof      = bus.m_eol && (row_q == LastRow);
    assign busy           = (state_q != StIdle);
    assign frame_done     = done;

endmodule

// File: tb/tb_mat_fifo_rd_stream.sv
// Scoreboard bench: runs OUT_REG=0 and OUT_REG=1 instances side by side on a 4x2 frame.
module tb_mat_fifo_rd_stream;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 2;
    localparam int unsigned NW = IW * IH;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        m_ready = 1'b1;
    logic [1:0]  busy, frame_done;
    int unsigned written = 0;
    logic [31:0] base = '0;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int rd_cnt[2], xfer[2], fd_cnt[2], fd_cyc[2], first_pop[2], last_pop[2];
    int max_out[2], emp_viol[2], stab_viol[2];
    logic        stall_q[2];
    logic [31:0] hold_d[2];
    logic [2:0]  hold_m[2];
    exp_t        exp_q[2][$];

    always #5 clk = ~clk;

    mat_fifo_rd_stream_if #(.DATA_WIDTH(W)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned L = 1 + g;
        int unsigned rptr;
        logic [W-1:0] stg [L];
        logic take;

        // FIFO model: word n of the current fill is base+n, returned L cycles after the read.
        assign take                 = bus[g].fifo_rd_en && !bus[g].fifo_empty;
        assign bus[g].fifo_empty    = (rptr >= written);
        assign bus[g].fifo_rd_data  = stg[L-1];
        assign bus[g].m_ready       = m_ready;

        always @(posedge clk or posedge rst) begin
            if (rst) rptr <= 0;
            else if (take) rptr <= rptr + 1;
        end

        always @(posedge clk) begin
            stg[0] <= take ? base + rptr : 32'hBAD0_BAD0;
            for (int k = 1; k < L; k++) stg[k] <= stg[k-1];
        end

        mat_fifo_rd_stream #(
            .DATA_WIDTH (W),
            .OUT_REG    (g),
            .IMG_WIDTH  (IW),
            .IMG_HEIGHT (IH)
        ) dut (
            .rd_clk      (clk),
            .rd_rst      (rst),
            .frame_start (frame_start),
            .bus         (bus[g]),
            .busy        (busy[g]),
            .frame_done  (frame_done[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic mon_one(input int i, input logic v, input logic r, input logic [31:0] d,
                           input logic [2:0] mk, input logic rd_en, input logic empty,
                           input logic fd);
        int   outst;
        exp_t e;
        outst = rd_cnt[i] - xfer[i];
        if (outst > max_out[i]) max_out[i] = outst;
        if (rd_en) begin
            rd_cnt[i]++;
            if (empty) emp_viol[i]++;
        end
        if (stall_q[i] && (!v || d !== hold_d[i] || mk !== hold_m[i])) stab_viol[i]++;
        stall_q[i] = v && !r;
        hold_d[i]  = d;
        hold_m[i]  = mk;
        if (v && r) begin
            if (exp_q[i].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL inst%0d_extra_word: got 0x%0h, want none", i, d);
            end else begin
                e = exp_q[i].pop_front();
                chk($sformatf("inst%0d_word%0d", i, xfer[i]), 64'({d, mk}),
                    64'({e.data, e.sof, e.eol, e.eof}));
            end
            if (xfer[i] == 0) first_pop[i] = cyc;
            last_pop[i] = cyc;
            xfer[i]++;
        end
        if (fd) begin
            fd_cnt[i]++;
            fd_cyc[i] = cyc;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                mon_one(0, bus[0].m_valid, bus[0].m_ready, bus[0].m_data,
                        {bus[0].m_sof, bus[0].m_eol, bus[0].m_eof},
                        bus[0].fifo_rd_en, bus[0].fifo_empty, frame_done[0]);
                mon_one(1, bus[1].m_valid, bus[1].m_ready, bus[1].m_data,
                        {bus[1].m_sof, bus[1].m_eol, bus[1].m_eof},
                        bus[1].fifo_rd_en, bus[1].fifo_empty, frame_done[1]);
            end
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 2; i++) begin
            rd_cnt[i] = 0;  xfer[i] = 0;      fd_cnt[i] = 0;    fd_cyc[i] = -1;
            first_pop[i] = 0; last_pop[i] = 0; max_out[i] = 0;
            emp_viol[i] = 0; stab_viol[i] = 0; stall_q[i] = 1'b0;
            exp_q[i].delete();
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        written = 0;
        clr_stats();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_frame();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < NW; n++) begin
                e.data = base + 32'(n);
                e.sof  = (n == 0);
                e.eol  = (n % IW == IW - 1);
                e.eof  = (n == NW - 1);
                exp_q[i].push_back(e);
            end
        end
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0 repeating.
    task automatic wait_idle(input string name, input int mode);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            m_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            if (busy == 2'b00 && exp_q[0].size() == 0 && exp_q[1].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        chk({name, "_finished"}, 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame_checks(input string t, input bit full_rate, input bit exact_lim);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_left%0d", t, i), 64'(exp_q[i].size()), 64'd0);
            chk($sformatf("%s_rdcnt%0d", t, i), 64'(rd_cnt[i]), 64'(NW));
            chk($sformatf("%s_donecnt%0d", t, i), 64'(fd_cnt[i]), 64'd1);
            chk($sformatf("%s_donecyc%0d", t, i), 64'(fd_cyc[i]), 64'(last_pop[i] + 1));
            chk($sformatf("%s_rd_when_empty%0d", t, i), 64'(emp_viol[i]), 64'd0);
            chk($sformatf("%s_unstable%0d", t, i), 64'(stab_viol[i]), 64'd0);
            if (exact_lim)
                chk($sformatf("%s_maxout%0d", t, i), 64'(max_out[i]), 64'(i + 2));
            else
                chk($sformatf("%s_maxout_le%0d", t, i), 64'(max_out[i] <= i + 2), 64'd1);
            if (full_rate)
                chk($sformatf("%s_span%0d", t, i), 64'(last_pop[i] - first_pop[i]),
                    64'(NW - 1));
        end
    endtask

    initial begin
        bit ok;
        clr_stats();
        fork
            monitor();
        join_none

        // Reset state.
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
            chk($sformatf("rst_done%0d", i), 64'(frame_done[i]), 64'd0);
        end
        chk("rst_valid0", 64'(bus[0].m_valid), 64'd0);
        chk("rst_valid1", 64'(bus[1].m_valid), 64'd0);
        chk("rst_rden0", 64'(bus[0].fifo_rd_en), 64'd0);
        chk("rst_data1", 64'(bus[1].m_data), 64'd0);

        // Full-rate transfer, FIFO preloaded with 0..7.
        base = 32'd0; written = NW;
        start_frame();
        wait_idle("full", 0);
        frame_checks("full", 1'b1, 1'b1);

        // Backpressure with m_ready 1,0,0,...
        reset_dut();
        base = 32'd0; written = NW;
        start_frame();
        wait_idle("bp", 1);
        frame_checks("bp", 1'b0, 1'b1);

        // Empty stall: 3 words, refill after 10 cycles.
        reset_dut();
        base = 32'd0; written = 3;
        start_frame();
        repeat (10) @(posedge clk);
        #1;
        chk("stall_held0", 64'(xfer[0]), 64'd3);
        chk("stall_held1", 64'(xfer[1]), 64'd3);
        written = NW;
        wait_idle("stall", 0);
        frame_checks("stall", 1'b0, 1'b0);

        // Reset after the 5th transfer, then restart with a fresh fill.
        reset_dut();
        base = 32'd0; written = NW;
        start_frame();
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (xfer[0] >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reach5", 64'(ok), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_valid0", 64'(bus[0].m_valid), 64'd0);
        chk("mid_valid1", 64'(bus[1].m_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rden0", 64'(bus[0].fifo_rd_en), 64'd0);
        chk("mid_rden1", 64'(bus[1].fifo_rd_en), 64'd0);
        chk("mid_marks0", 64'({bus[0].m_sof, bus[0].m_eol, bus[0].m_eof}), 64'd0);
        chk("mid_data0", 64'(bus[0].m_data), 64'd0);
        written = 0;
        clr_stats();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        base = 32'h100; written = NW;
        start_frame();
        repeat (3) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        wait_idle("restart", 0);
        repeat (6) @(posedge clk);
        #1;
        chk("restart_stays_idle", 64'(busy), 64'd0);
        frame_checks("restart", 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
